div_seq: RTL and testbench

Multi-cycle sequencer for the RV32M divide/remainder instructions (DIV, DIVU, REM, REMU) in the execute stage. It accepts operands already resolved by decode and forwarding, and runs a 32-iteration restoring division on operand magnitudes. It holds the pipeline with a stall request while it works, then issues a single-cycle register-write request with the signed or unsigned result. MUL* stays single-cycle elsewhere; this block sees only funct3[2]=1 ops of the R/M opcode.

---
 rtl/div_seq_pkg.sv | 41 ++++
 rtl/div_step.sv | 28 ++
 rtl/div_seq.sv | 155 +++++++++++++++
 tb/tb_div_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// Shared widths, RV32M divide funct3 codes and the per-operation context
// carried by the divide sequencer.
package div_seq_pkg;

    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned RADDR_WIDTH = 5;
    localparam int unsigned DIV_CYCLES  = 32;
    localparam int unsigned CNT_WIDTH   = $clog2(DIV_CYCLES);

    localparam logic [2:0] DIV_OP  = 3'b100;
    localparam logic [2:0] DIVU_OP = 3'b101;
    localparam logic [2:0] REM_OP  = 3'b110;
    localparam logic [2:0] REMU_OP = 3'b111;

    localparam logic [RADDR_WIDTH-1:0] ZERO_REG = '0;
    localparam logic [DATA_WIDTH-1:0]  INT_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // Operation context captured when a divide is accepted.
    typedef struct packed {
        logic                   rem_sel;
        logic                   neg_quo;
        logic                   neg_rem;
        logic [RADDR_WIDTH-1:0] waddr;
    } div_ctx_t;

    localparam div_ctx_t CTX_RESET = '{
        rem_sel: 1'b0,
        neg_quo: 1'b0,
        neg_rem: 1'b0,
        waddr:   ZERO_REG
    };

    // Conditional two's-complement negation.
    function automatic logic [DATA_WIDTH-1:0] neg_if(
        input logic                  neg,
        input logic [DATA_WIDTH-1:0] val
    );
        return neg ? DATA_WIDTH'(-val) : val;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left by one, then
// trial-subtract the divisor magnitude and restore on borrow.
module div_step
    import div_seq_pkg::*;
(
    input  logic [DATA_WIDTH:0]   rem,
    input  logic [DATA_WIDTH-1:0] quo,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH:0]   rem_next,
    output logic [DATA_WIDTH-1:0] quo_next
);

    localparam int unsigned REM_W   = DATA_WIDTH + 1;
    localparam int unsigned SHIFT_W = DATA_WIDTH + 2;

    logic [SHIFT_W-1:0] shifted;
    logic [SHIFT_W-1:0] diff;
    logic               borrow;

    // Extra top bit turns the difference's MSB into a borrow flag.
    assign shifted = {rem, quo[DATA_WIDTH-1]};
    assign diff    = shifted - SHIFT_W'(divisor);
    assign borrow  = diff[SHIFT_W-1];

    assign rem_next = borrow ? shifted[REM_W-1:0] : diff[REM_W-1:0];
    assign quo_next = {quo[DATA_WIDTH-2:0], ~borrow};

endmodule

// File: rtl/div_seq.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer: stalls the pipeline during a
// 32-step restoring division on magnitudes, then pulses one register write.
module div_seq
    import div_seq_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [2:0]             funct3_i,
    input  logic [DATA_WIDTH-1:0]  dividend_i,
    input  logic [DATA_WIDTH-1:0]  divisor_i,
    input  logic [RADDR_WIDTH-1:0] waddr_i,
    input  logic                   flush_i,
    output logic                   stall_req_o,
    output logic                   busy_o,
    output logic [DATA_WIDTH-1:0]  result_o,
    output logic                   result_valid_o,
    output logic                   reg_we_o,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DIV_CYCLES - 1);

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH:0]   rem_q, rem_d, step_rem;
    logic [DATA_WIDTH-1:0] quo_q, quo_d, step_quo;
    logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
    div_ctx_t              ctx_q, ctx_d;

    logic                  op_signed;
    logic                  neg_a, neg_b;
    logic                  div_zero, overflow, accept;
    logic [DATA_WIDTH-1:0] mag_a, mag_b;
    logic [DATA_WIDTH-1:0] quo_fix, rem_fix;

    // Operand decode on the incoming EX-stage instruction.
    assign op_signed = (funct3_i == DIV_OP) || (funct3_i == REM_OP);
    assign neg_a     = op_signed & dividend_i[DATA_WIDTH-1];
    assign neg_b     = op_signed & divisor_i[DATA_WIDTH-1];
    assign mag_a     = neg_if(neg_a, dividend_i);
    assign mag_b     = neg_if(neg_b, divisor_i);
    assign div_zero  = (divisor_i == '0);
    assign overflow  = op_signed && (dividend_i == INT_MIN) && (divisor_i == '1);
    assign accept    = (state_q == ST_IDLE) && start_i && funct3_i[2] && !flush_i;

    div_step u_div_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvs_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            ctx_q <= CTX_RESET;
        end else begin
            cnt_q <= cnt_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            ctx_q <= ctx_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        ctx_d   = ctx_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ctx_d.rem_sel = funct3_i[1];
                    ctx_d.waddr   = waddr_i;
                    ctx_d.neg_quo = 1'b0;
                    ctx_d.neg_rem = 1'b0;
                    cnt_d         = '0;
                    dvs_d         = mag_b;
                    state_d       = ST_DONE;
                    // Special cases finish immediately with no sign fix-up.
                    if (div_zero) begin
                        quo_d = '1;
                        rem_d = {1'b0, dividend_i};
                    end else if (overflow) begin
                        quo_d = INT_MIN;
                        rem_d = '0;
                    end else begin
                        quo_d         = mag_a;
                        rem_d         = '0;
                        ctx_d.neg_quo = neg_a ^ neg_b;
                        ctx_d.neg_rem = neg_a;
                        state_d       = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_WIDTH'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (flush_i) begin
            state_d = ST_IDLE;
        end
    end

    // Outputs derive from registered state only; stall is the one combinational path.
    assign quo_fix = neg_if(ctx_q.neg_quo, quo_q);
    assign rem_fix = neg_if(ctx_q.neg_rem, rem_q[DATA_WIDTH-1:0]);

    assign busy_o         = (state_q != ST_IDLE);
    assign stall_req_o    = accept || (state_q == ST_CALC);
    assign result_valid_o = (state_q == ST_DONE);
    assign reg_we_o       = (state_q == ST_DONE);
    assign reg_waddr_o    = (state_q == ST_DONE) ? ctx_q.waddr : ZERO_REG;
    assign result_o       = (state_q != ST_DONE) ? '0
                          : (ctx_q.rem_sel ? rem_fix : quo_fix);

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed RV32M corner cases plus random
// operations against an arithmetic reference model.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        flush;
    logic        stall;
    logic        busy;
    logic [31:0] res;
    logic        valid;
    logic        we;
    logic [4:0]  waddr_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    div_seq dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .funct3_i       (funct3),
        .dividend_i     (a),
        .divisor_i      (b),
        .waddr_i        (rd),
        .flush_i        (flush),
        .stall_req_o    (stall),
        .busy_o         (busy),
        .result_o       (res),
        .result_valid_o (valid),
        .reg_we_o       (we),
        .reg_waddr_o    (waddr_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // RV32M semantics computed directly with signed/unsigned arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] x,
                                          input logic [31:0] y);
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        logic               ovf;
        sx  = x;
        sy  = y;
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (f3)
            3'b100:  return (y == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sx / sy));
            3'b101:  return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'b110:  return (y == 0) ? x : (ovf ? 32'd0 : 32'(sx % sy));
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f3, input logic [31:0] x,
                                     input logic [31:0] y);
        logic is_signed;
        is_signed = !f3[0];
        if (y == 0) return 1;
        if (is_signed && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 4))
            0: return 32'($urandom_range(0, 200));
            1: return 32'(-$urandom_range(1, 200));
            2: begin
                logic [31:0] specials [6];
                specials = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd2};
                return specials[$urandom_range(0, 5)];
            end
            default: return $urandom;
        endcase
    endfunction

    // Drive a start for one op in cycle 0 and check the cycle-0 stall.
    task automatic issue(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] r);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        flush  = 1'b0;
        start  = 1'b1;
        funct3 = f3;
        a      = x;
        b      = y;
        rd     = r;
        @(negedge clk);
        check("stall_c0", 32'(stall), 32'd1);
        check("busy_c0", 32'(busy), 32'd0);
    endtask

    // Wait (bounded) for the result pulse and check timing and payload.
    task automatic finish_op(input string tag, input logic [4:0] r, input logic [31:0] exp,
                             input int exp_lat, input bit hold);
        int lat    = 0;
        int nstall = 0;
        int early  = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (!hold) start = 1'b0;
            @(negedge clk);
            if (valid) begin
                lat = c;
                break;
            end
            if (stall) nstall++;
            if (we || waddr_o != 0 || res != 0) early++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, res, exp);
        check({tag, "_we"}, 32'(we), 32'd1);
        check({tag, "_waddr"}, 32'(waddr_o), 32'(r));
        check({tag, "_stall_in_done"}, 32'(stall), 32'd0);
        check({tag, "_stall_cycles"}, 32'(nstall), 32'(exp_lat - 1));
        check({tag, "_quiet_before"}, 32'(early), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check({tag, "_idle_after"}, {29'd0, busy, valid, we}, 32'd0);
        check({tag, "_waddr_after"}, 32'(waddr_o), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] x,
                          input logic [31:0] y, input logic [4:0] r, input logic [31:0] exp,
                          input bit hold);
        issue(f3, x, y, r);
        finish_op(tag, r, exp, model_lat(f3, x, y), hold);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int valids;
        rst    = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'b000;
        a      = '0;
        b      = '0;
        rd     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_flags", {28'd0, stall, busy, valid, we}, 32'd0);
        check("reset_result", res, 32'd0);
        check("reset_waddr", 32'(waddr_o), 32'd0);

        // Directed corner cases with hand-derived results.
        run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 5'd3, 32'd14, 1'b0);
        run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 5'd4, 32'd2, 1'b0);
        run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 1'b0);
        run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 1'b0);
        run_op("rem_7_m2", 3'b110, 32'd7, 32'hFFFF_FFFE, 5'd7, 32'd1, 1'b0);
        run_op("divu_5_0", 3'b101, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 1'b0);
        run_op("rem_m5_0", 3'b110, 32'hFFFF_FFFB, 32'd0, 5'd9, 32'hFFFF_FFFB, 1'b0);
        run_op("div_m7_0", 3'b100, 32'hFFFF_FFF9, 32'd0, 5'd10, 32'hFFFF_FFFF, 1'b0);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1'b0);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 1'b0);
        run_op("divu_min_m1", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0, 1'b0);
        run_op("divu_hold", 3'b101, 32'd100, 32'd7, 5'd14, 32'd14, 1'b1);

        // Flush in cycle 10, then a fresh start in cycle 11 completing at 44.
        issue(3'b101, 32'd1000, 32'd3, 5'd15);
        valids = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (c == 10) flush = 1'b1;
            @(negedge clk);
            if (valid || we) valids++;
        end
        issue(3'b110, 32'hFFFF_FF9C, 32'd7, 5'd16);
        check("flush_no_result", 32'(valids), 32'd0);
        finish_op("after_flush", 5'd16, 32'hFFFF_FFFE, 33, 1'b0);

        // Synchronous reset in cycle 20 of a running divide.
        issue(3'b100, 32'd12345, 32'd67, 5'd17);
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (c == 20) rst = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_flags", {28'd0, stall, busy, valid, we}, 32'd0);
        check("rst_mid_result", res, 32'd0);
        check("rst_mid_waddr", 32'(waddr_o), 32'd0);

        // Randomised operations against the model.
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3;
            logic [31:0] x;
            logic [31:0] y;
            logic [4:0]  r;
            f3 = 3'(4 + $urandom_range(0, 3));
            x  = rand_operand();
            y  = rand_operand();
            r  = 5'($urandom_range(1, 31));
            run_op($sformatf("rand%0d_f%0d", i, f3), f3, x, y, r, model(f3, x, y),
                   1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
